// File: rtl/sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sub_pipe
// Purpose  : Pipelined multi-lane subtractor with valid/ready handshakes.
//            Every lane computes z = a - b (mod 2^WIDTH) in the first stage.
//            The flag is borrow in unsigned mode and overflow in signed mode.
//            The remaining stages only delay the result. Stalls collapse
//            bubbles, so any empty slot can load while a later slot is held.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            in_valid/in_ready    - upstream handshake
//            in_signed            - 1 = two's complement, 0 = unsigned
//            in_a/in_b            - packed operands, lane k at [k*WIDTH +: WIDTH]
//            out_valid/out_ready  - downstream handshake
//            out_z/out_flag       - packed differences / per-lane flags
//            res_count            - wrapping count of accepted results
// Options  : SUB_PIPE_SAT_EN      - clamp flagged lanes instead of wrapping
// Revision : 1.0 - initial release
// ============================================================================
module sub_pipe #(
  parameter int WIDTH  = 64,
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_signed,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_z,
  output logic [LANES-1:0]       out_flag,
  output logic [CNT_W-1:0]       res_count
);

  localparam int DW = LANES * WIDTH;

  logic [DW-1:0]    w_z_calc;
  logic [LANES-1:0] w_flag_calc;

  // Per-lane arithmetic, evaluated on the input side of slot 0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_diff;   // extra MSB is the unsigned borrow
    logic             w_ovf;
    logic             w_flag;
    logic [WIDTH-1:0] w_z;

    assign w_a    = in_a[k*WIDTH +: WIDTH];
    assign w_b    = in_b[k*WIDTH +: WIDTH];
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    // Signed overflow is only possible when the operand signs differ.
    assign w_ovf  = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != w_a[WIDTH-1]);
    assign w_flag = in_signed ? w_ovf : w_diff[WIDTH];

`ifdef SUB_PIPE_SAT_EN
    always_comb begin
      w_z = w_diff[WIDTH-1:0];
      if (w_flag) begin
        if (!in_signed) begin
          w_z = '0;
        end else if (w_a[WIDTH-1]) begin
          w_z = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          w_z = {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
    end
`else
    assign w_z = w_diff[WIDTH-1:0];
`endif

    assign w_z_calc[k*WIDTH +: WIDTH] = w_z;
    assign w_flag_calc[k]             = w_flag;
  end

  // Index 0 is the input side; index s+1 is the content of slot s.
  logic [STAGES:0]  w_stg_v;
  logic [DW-1:0]    w_stg_z [STAGES+1];
  logic [LANES-1:0] w_stg_f [STAGES+1];
  logic [STAGES-1:0] w_slot_rdy;

  assign w_stg_v[0] = in_valid;
  assign w_stg_z[0] = w_z_calc;
  assign w_stg_f[0] = w_flag_calc;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             v_q;
    logic [DW-1:0]    z_q;
    logic [LANES-1:0] f_q;

    // A slot can load unless it and every later slot are full while the
    // output is stalled. This is the unrolled form of the ready chain.
    assign w_slot_rdy[s] = out_ready | ~(&w_stg_v[STAGES:s+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        z_q <= '0;
        f_q <= '0;
      end else if (w_slot_rdy[s]) begin
        v_q <= w_stg_v[s];
        if (w_stg_v[s]) begin
          z_q <= w_stg_z[s];
          f_q <= w_stg_f[s];
        end
      end
    end

    assign w_stg_v[s+1] = v_q;
    assign w_stg_z[s+1] = z_q;
    assign w_stg_f[s+1] = f_q;
  end

  assign in_ready  = w_slot_rdy[0];
  assign out_valid = w_stg_v[STAGES];
  assign out_z     = w_stg_z[STAGES];
  assign out_flag  = w_stg_f[STAGES];

  // Accepted-result counter
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign res_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_pipe
// Purpose  : Directed and streaming checks for sub_pipe (WIDTH=64, LANES=2,
//            STAGES=2). Expected values are hand constants or come from a
//            lane model that uses a wide signed range test for overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_pipe;

  localparam int W = 64;
  localparam int L = 2;
  localparam int S = 2;
  localparam int C = 16;

  localparam logic [63:0] c_all1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_min  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] c_max  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_m2   = 64'hFFFF_FFFF_FFFF_FFFE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [L*W-1:0]   in_a;
  logic [L*W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [L*W-1:0]   out_z;
  logic [L-1:0]     out_flag;
  logic [C-1:0]     res_count;

  always #5 clk = ~clk;

  sub_pipe #(.WIDTH(W), .LANES(L), .STAGES(S), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flag(out_flag), .res_count(res_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [127:0] qa [$];
  logic [127:0] qb [$];
  bit           qs [$];
  logic [127:0] qz [$];
  logic [1:0]   qf [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void lane_model(input logic [63:0] a, input logic [63:0] b, input bit s,
                                     output logic [63:0] z, output bit f);
    logic signed [65:0] sd;
    z  = a - b;
    sd = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    // Signed result fits in 64 bits only if its top three bits agree.
    f  = s ? (sd[65:63] != {3{sd[65]}}) : (a < b);
`ifdef SUB_PIPE_SAT_EN
    if (f) z = !s ? 64'd0 : (a[63] ? c_min : c_max);
`endif
  endfunction

  task automatic push_txn(input logic [127:0] a, input logic [127:0] b, input bit s);
    logic [63:0] z0, z1;
    bit f0, f1;
    lane_model(a[63:0], b[63:0], s, z0, f0);
    lane_model(a[127:64], b[127:64], s, z1, f1);
    qa.push_back(a); qb.push_back(b); qs.push_back(s);
    qz.push_back({z1, z0}); qf.push_back({f1, f0});
  endtask

  // One clock of driver + monitor, entered and left at 1 time unit after posedge.
  task automatic step(input bit ordy);
    bit acc, xfer;
    out_ready = ordy;
    if (qa.size() > 0) begin
      in_valid = 1'b1; in_a = qa[0]; in_b = qb[0]; in_signed = qs[0];
    end else begin
      in_valid = 1'b0;
    end
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (xfer) begin
      if (qz.size() == 0) begin
        check("unexpected_out", 128'(out_valid), 128'(0));
      end else begin
        check("stream_z", out_z, qz[0]);
        check("stream_flag", 128'(out_flag), 128'(qf[0]));
        void'(qz.pop_front()); void'(qf.pop_front());
        exp_cnt++;
      end
    end
    @(posedge clk); #1;
    if (acc) begin
      void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
    end
  endtask

  task automatic run_stream(input bit rnd, input int budget);
    int cyc = 0;
    while ((qa.size() > 0 || qz.size() > 0) && cyc < budget) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    check("stream_drained", 128'(qa.size() + qz.size()), 128'(0));
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input bit s, input logic [127:0] ez, input logic [1:0] ef);
    out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
    #1;
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat_early"}, 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_z"}, out_z, ez);
    check({tag, "_flag"}, 128'(out_flag), 128'(ef));
    @(posedge clk); #1;
    exp_cnt++;
    check({tag, "_cnt"}, 128'(res_count), 128'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] hold;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_z", out_z, 128'(0));
    check("rst_out_flag", 128'(out_flag), 128'(0));
    check("rst_res_count", 128'(res_count), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned basic: lane1 100-100, lane0 5-3
    directed("ubasic", {64'd100, 64'd5}, {64'd100, 64'd3}, 1'b0, {64'd0, 64'd2}, 2'b00);
`ifdef SUB_PIPE_SAT_EN
    directed("uunder", {64'd7, 64'd0}, {64'd2, 64'd1}, 1'b0, {64'd5, 64'd0}, 2'b01);
    directed("sneg",   {c_min, c_all1}, {64'd1, 64'd1}, 1'b1, {c_min, c_m2}, 2'b10);
    directed("spos",   {64'd5, c_max}, {64'd7, c_all1}, 1'b1, {c_m2, c_max}, 2'b01);
`else
    directed("uunder", {64'd7, 64'd0}, {64'd2, 64'd1}, 1'b0, {64'd5, c_all1}, 2'b01);
    directed("sneg",   {c_min, c_all1}, {64'd1, 64'd1}, 1'b1, {c_max, c_m2}, 2'b10);
    directed("spos",   {64'd5, c_max}, {64'd7, c_all1}, 1'b1, {c_m2, c_min}, 2'b01);
`endif

    // Backpressure: four distinct transactions against a stalled output
    for (int i = 0; i < 4; i++) begin
      push_txn({64'(i + 10), 64'(3 * i + 1)}, {64'(2 * i), 64'(i + 2)}, 1'(i % 2));
    end
    repeat (4) step(1'b0);
    check("bp_accepted", 128'(4 - qa.size()), 128'(2));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    check("bp_head_z", out_z, qz[0]);
    hold = out_z;
    step(1'b0);
    check("bp_stable_z", out_z, hold);
    check("bp_stable_valid", 128'(out_valid), 128'(1));
    run_stream(1'b0, 50);
    check("bp_res_count", 128'(res_count), 128'(exp_cnt));

    // Random stream, mixed modes, random downstream stalls
    for (int i = 0; i < 20; i++) begin
      push_txn({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    run_stream(1'b1, 500);
    check("rand_res_count", 128'(res_count), 128'(exp_cnt));

    // Reset with two transactions in flight
    push_txn({64'd9, 64'd8}, {64'd1, 64'd2}, 1'b0);
    push_txn({64'd6, 64'd5}, {64'd3, 64'd4}, 1'b1);
    step(1'b0);
    step(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 128'(out_valid), 128'(0));
    check("mrst_res_count", 128'(res_count), 128'(0));
    check("mrst_in_ready", 128'(in_ready), 128'(1));
    qa.delete(); qb.delete(); qs.delete(); qz.delete(); qf.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mrst_no_stale", 128'(seen), 128'(0));
    directed("post_rst", {64'd50, 64'd40}, {64'd20, 64'd1}, 1'b0, {64'd30, 64'd39}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
